// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, PC step, FSM encoding.
// Also holds the sign-extension helper used by the PC arithmetic.
package inst_fetch_pkg;

    localparam int          INSTRUCTION_WIDTH = 32;
    localparam logic [31:0] PC_INC            = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] sext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/inst_fetch_next_pc.sv
// Next-PC selection: sequential step, or PC-relative branch with a word-scaled offset.
// Purely combinational so later jump/branch work can reuse it.
module inst_fetch_next_pc
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  branch_taken,
    input  logic [15:0]           branch_imm,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    logic [31:0] branch_offset;

    assign branch_offset = sext16(branch_imm) << 2;

    // All sums are modulo 2^ADDR_WIDTH; wrap-around is intended.
    always_comb begin
        next_pc = pc + ADDR_WIDTH'(PC_INC);
        if (branch_taken) begin
            next_pc = next_pc + ADDR_WIDTH'(branch_offset);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from instruction
// memory, and holds it in the instruction register until decode accepts it.
//
//   state  | meaning
//   S_IDLE | just out of reset, nothing issued yet
//   S_REQ  | request for pc_out presented to memory
//   S_WAIT | request accepted, waiting for the response word
//   S_HOLD | instruction valid to decode, waiting for consume
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = INSTRUCTION_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  inst_req_valid,
    input  logic                  inst_req_ready,
    output logic [ADDR_WIDTH-1:0] inst_req_addr,
    input  logic                  inst_resp_valid,
    input  logic [DATA_WIDTH-1:0] inst_resp_data,
    output logic                  inst_resp_ready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  branch_taken,
    input  logic [15:0]           branch_imm,
    output logic [31:0]           inst_count
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic                  resp_fire;
    logic                  dec_fire;
    logic [ADDR_WIDTH-1:0] pc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs depend on state only; inputs merely steer transitions.
    always_comb begin
        state_nxt       = state;
        inst_req_valid  = 1'b0;
        inst_resp_ready = 1'b0;
        inst_valid      = 1'b0;
        resp_fire       = 1'b0;
        dec_fire        = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                inst_req_valid = 1'b1;
                if (inst_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                inst_resp_ready = 1'b1;
                if (inst_resp_valid) begin
                    resp_fire = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    dec_fire  = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    inst_fetch_next_pc #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_pc (
        .pc           (pc_out),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .next_pc      (pc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out     <= ADDR_WIDTH'(RESET_PC);
            inst_out   <= '0;
            inst_count <= '0;
        end else begin
            if (resp_fire) begin
                inst_out <= inst_resp_data;
            end
            if (dec_fire) begin
                pc_out     <= pc_nxt;
                inst_count <= inst_count + 32'd1;
            end
        end
    end

    assign inst_req_addr = pc_out;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized stalls, words and branches,
// checked against a transaction-level model of PC, instruction register and count.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_req_addr;
    logic        inst_resp_valid;
    logic [31:0] inst_resp_data;
    logic        inst_resp_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic [31:0] inst_count;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_addr   (inst_req_addr),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_data  (inst_resp_data),
        .inst_resp_ready (inst_resp_ready),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .branch_taken    (branch_taken),
        .branch_imm      (branch_imm),
        .inst_count      (inst_count)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_consume = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_count;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_valid"}, 32'(inst_req_valid), 32'd0);
        chk({tag, "_resp_ready"}, 32'(inst_resp_ready), 32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_inst"}, inst_out, 32'h0);
        chk({tag, "_count"}, inst_count, 32'h0);
    endtask

    // One complete instruction, entered and left with the DUT presenting a request.
    task automatic fetch_one(input int req_stall, input int resp_delay, input int dec_stall,
                             input logic [31:0] word, input logic taken,
                             input logic [15:0] imm, input bit chk_period);
        int delta;
        chk("req_valid", 32'(inst_req_valid), 32'd1);
        chk("req_addr", inst_req_addr, exp_pc);
        for (int i = 0; i < req_stall; i++) begin
            inst_req_ready = 1'b0;
            inst_resp_valid = (i == 0);
            inst_resp_data  = $urandom;
            tick();
            inst_resp_valid = 1'b0;
            chk("stall_req_valid", 32'(inst_req_valid), 32'd1);
            chk("stall_req_addr", inst_req_addr, exp_pc);
            chk("stall_inst_kept", inst_out, exp_inst);
        end
        inst_req_ready = 1'b1;
        tick();
        inst_req_ready = 1'b0;
        chk("wait_req_valid", 32'(inst_req_valid), 32'd0);
        chk("wait_resp_ready", 32'(inst_resp_ready), 32'd1);
        for (int i = 0; i < resp_delay; i++) begin
            tick();
            chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        end
        inst_resp_valid = 1'b1;
        inst_resp_data  = word;
        tick();
        inst_resp_valid = 1'b0;
        inst_resp_data  = $urandom;
        exp_inst = word;
        chk("hold_inst_valid", 32'(inst_valid), 32'd1);
        chk("hold_inst", inst_out, exp_inst);
        chk("hold_pc", pc_out, exp_pc);
        chk("hold_resp_ready", 32'(inst_resp_ready), 32'd0);
        for (int i = 0; i < dec_stall; i++) begin
            inst_ready      = 1'b0;
            branch_taken    = 1'($urandom);
            branch_imm      = 16'($urandom);
            inst_resp_valid = (i == 0);
            tick();
            inst_resp_valid = 1'b0;
            chk("dstall_valid", 32'(inst_valid), 32'd1);
            chk("dstall_inst", inst_out, exp_inst);
            chk("dstall_pc", pc_out, exp_pc);
            chk("dstall_no_req", 32'(inst_req_valid), 32'd0);
            chk("dstall_count", inst_count, exp_count);
        end
        inst_ready   = 1'b1;
        branch_taken = taken;
        branch_imm   = imm;
        tick();
        inst_ready   = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'($urandom);
        delta = taken ? int'($signed(imm)) * 4 : 0;
        exp_pc    = exp_pc + 32'd4 + 32'(delta);
        exp_count = exp_count + 32'd1;
        if (chk_period) begin
            chk("consume_period", 32'(cyc - last_consume), 32'd3);
        end
        last_consume = cyc;
        chk("count", inst_count, exp_count);
        chk("after_valid", 32'(inst_valid), 32'd0);
        chk("next_req_valid", 32'(inst_req_valid), 32'd1);
        chk("next_addr", inst_req_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          off;

        rst             = 1'b1;
        inst_req_ready  = 1'b0;
        inst_resp_valid = 1'b0;
        inst_resp_data  = '0;
        inst_ready      = 1'b0;
        branch_taken    = 1'b0;
        branch_imm      = '0;
        exp_pc    = 32'h0;
        exp_inst  = 32'h0;
        exp_count = 32'h0;

        tick();
        tick();
        chk_reset_values("reset");
        rst = 1'b0;
        chk("idle_no_req", 32'(inst_req_valid), 32'd0);
        tick();

        // Sequential fetches, always-ready memory; back-pressure on the third at 0x8.
        fetch_one(0, 0, 0, 32'h2008_0001, 1'b0, 16'h0000, 1'b0);
        fetch_one(0, 0, 0, 32'h2009_0002, 1'b0, 16'h0000, 1'b1);
        fetch_one(4, 0, 0, 32'h200A_0003, 1'b0, 16'h0000, 1'b0);
        chk("three_consumed", inst_count, 32'd3);

        // Decode stall at 0xC with spurious responses during the hold.
        fetch_one(0, 0, 5, 32'h2408_0005, 1'b0, 16'h0000, 1'b0);

        // Branches from 0x10.
        fetch_one(0, 0, 0, 32'h1000_FFFF, 1'b1, 16'hFFFF, 1'b0);
        chk("br_back_self", exp_pc, 32'h10);
        fetch_one(0, 1, 0, 32'h1000_0003, 1'b0, 16'h0003, 1'b0);
        chk("br_not_taken", inst_req_addr, 32'h14);
        fetch_one(1, 0, 1, 32'h1000_FFFE, 1'b1, 16'hFFFE, 1'b0);
        fetch_one(0, 0, 0, 32'h1000_0003, 1'b1, 16'h0003, 1'b0);
        chk("br_fwd", inst_req_addr, 32'h20);

        // Randomized traffic with short branches.
        for (int n = 0; n < 24; n++) begin
            off = int'($urandom_range(0, 15)) - 8;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom, 1'($urandom),
                      off[15:0], 1'b0);
        end

        // Steer to 0x40, then reset while waiting for the response.
        d = 32'h40 - exp_pc - 32'd4;
        fetch_one(0, 0, 0, $urandom, 1'b1, d[17:2], 1'b0);
        chk("at_0x40", inst_req_addr, 32'h40);
        inst_req_ready = 1'b1;
        tick();
        inst_req_ready = 1'b0;
        chk("mid_wait", 32'(inst_resp_ready), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        exp_pc    = 32'h0;
        exp_inst  = 32'h0;
        exp_count = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_idle", 32'(inst_req_valid), 32'd0);
        tick();

        // PC wrap: 0 -> 0xFFFF_FFFC -> 0.
        fetch_one(0, 0, 0, $urandom, 1'b1, 16'hFFFE, 1'b0);
        chk("wrap_low", inst_req_addr, 32'hFFFF_FFFC);
        fetch_one(0, 0, 0, $urandom, 1'b0, 16'h1234, 1'b0);
        chk("wrap_zero", inst_req_addr, 32'h0);
        chk("count_after_rst", inst_count, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
